seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//  Serial pattern transmitter. Driving side of the serial-bit detection path:
//  accepts a parallel pattern word over a valid/ready handshake and emits it
//  MSB-first, one bit per clk, repeated a programmable number of times with
//  optional idle gaps. Its output feeds the serial sequence detectors directly.
//  The default pattern is 4'b1001.
// PARAMETERS
//  PAT_W        4        pattern width in bits (>=2)
//  REP_W        4        width of repetition-count input
//  GAP_W        4        width of inter-repetition gap input
// PORTS
//  clk             in   1      clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  pat_valid       in   1      pattern request valid
//  pat_ready       out  1      block idle, can accept request
//  pat_data        in   PAT_W  pattern, MSB sent first
//  rep_cnt         in   REP_W  number of repetitions; 0 is treated as 1
//  gap_cycles      in   GAP_W  idle cycles between repetitions; 0 = back-to-back
//  abort           in   1      synchronous cancel of current request
//  data_out        out  1      serial bit; 0 whenever data_out_valid=0
//  data_out_valid  out  1      data_out carries a pattern bit this cycle
//  busy            out  1      request in progress (SHIFT or GAP)
//  frame_done      out  1      1-cycle pulse in the cycle the final bit is driven
// BEHAVIOUR
//  - Reset: state IDLE, data_out=0, data_out_valid=0, busy=0, frame_done=0,
//    counters and shift register 0. pat_ready=(state==IDLE), so it is 1 during reset.
//  - FSM states: IDLE, SHIFT, GAP.
//  - IDLE: pat_ready=1. On pat_valid&&pat_ready, latch pat_data, rep_cnt and
//    gap_cycles. Go to SHIFT. The first bit appears on data_out in the next cycle,
//    giving a latency of 1.
//  - SHIFT: data_out=shreg[PAT_W-1] and data_out_valid=1. Shift left every cycle.
//    The bit counter runs from PAT_W-1 down to 0.
//  - Last bit of a repetition, when repetitions remain:
//    - gap=0: reload shreg from the latched pattern and stay in SHIFT, with no
//      bubble between repetitions.
//    - gap>0: go to GAP.
//  - Last bit of the last repetition: frame_done=1 in that cycle; next state IDLE.
//  - GAP: data_out=0 and data_out_valid=0 for exactly gap_cycles cycles. Then SHIFT
//    with the pattern reloaded.
//  - Outputs data_out, data_out_valid, frame_done and busy are registered.
//  - pat_valid while busy: ignored. The request is not consumed. It is accepted on
//    the first IDLE cycle that still sees pat_valid=1.
//  - Acceptance edge: the acceptance cycle after frame_done is the earliest point a
//    new request can start. No back-to-back request chaining.
//  - abort: highest priority, sampled in any state.
//    - In SHIFT/GAP: next cycle state=IDLE, data_out_valid=0, no frame_done.
//    - In IDLE: abort with pat_valid blocks acceptance that cycle.
//  - Latched pattern and rep/gap values are immune to input changes mid-request.
//  - Counters do not wrap. rep_cnt=2^REP_W-1 and gap_cycles=2^GAP_W-1 are legal
//    maxima.
//  - reset_n asserted mid-operation: all outputs go to reset values immediately.
//    The partial frame is discarded.
// STRUCTURE
//  - Package seq_pkg:
//    - typedef enum tx_state_t {IDLE,SHIFT,GAP}
//    - localparam DEFAULT_PATTERN=4'b1001, shared with the detectors
//  - Sub-module seq_cnt_down: loadable down-counter with a zero flag and
//    parameterised width. Instantiated three times: bit, repetition and gap counters.
//  - Shift register and FSM are local to seq_pattern_tx.
// TESTING
//  1. Reset, pat=1001, rep=1, gap=0 accepted at cycle 0.
//     -> Cycles 1-4: data_out=1,0,0,1 with valid=1; frame_done at cycle 4;
//        pat_ready=1 at cycle 5.
//     -> In loopback to the 1001 detector, sequence_detected pulses once.
//  2. pat=1001, rep=3, gap=0.
//     -> 12 contiguous valid bits 100110011001; a single frame_done on bit 12.
//  3. pat=1001, rep=2, gap=2.
//     -> Valid bits 1001, then valid=0 for 2 cycles, then 1001.
//     -> 10 cycles from first bit to frame_done.
//  4. abort asserted in SHIFT on the 2nd bit.
//     -> Next cycle valid=0 and pat_ready=1; no frame_done.
//     -> A new request is accepted the following cycle.
//  5. pat_valid held high while busy.
//     -> Not accepted until IDLE, then accepted exactly once.
//     -> rep=0 request -> one repetition.
//  6. reset_n dropped mid-SHIFT, async to clk.
//     -> data_out/valid/busy go to 0 immediately; after release, state is IDLE
//        and pat_ready=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern path.
// Used by the transmitter and the sequence detectors.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request and serial-output bundle of the pattern transmitter.
// master drives requests, slave is the transmitter.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) ();

    logic             pat_valid;
    logic             pat_ready;
    logic [PAT_W-1:0] pat_data;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cycles;
    logic             abort;
    logic             data_out;
    logic             data_out_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output pat_valid, pat_data, rep_cnt, gap_cycles, abort,
        input  pat_ready, data_out, data_out_valid, busy, frame_done
    );

    modport slave (
        input  pat_valid, pat_data, rep_cnt, gap_cycles, abort,
        output pat_ready, data_out, data_out_valid, busy, frame_done
    );

endinterface

// File: rtl/seq_cnt_down.sv
// Loadable down-counter with zero flag.
// Saturates at zero instead of wrapping.
module seq_cnt_down #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    // load wins over decrement; hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first, repeated,
// with optional idle gaps between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input logic clk,
    input logic reset_n,
    seq_pattern_tx_if.slave bus
);

    localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    tx_state_t        state, state_n;
    logic [PAT_W-1:0] shreg, shreg_n;
    logic [PAT_W-1:0] pat_l;
    logic [GAP_W-1:0] gap_l;
    logic             latch;

    logic             dout_q, dout_n;
    logic             dv_q, dv_n;
    logic             fd_q, fd_n;
    logic             busy_q;

    logic             bit_ld, bit_dec, bit_zero;
    logic [BW-1:0]    bit_count;
    logic             rep_ld, rep_dec, rep_zero;
    logic [REP_W-1:0] rep_ldv, rep_count_unused;
    logic             gap_ld, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_ldv, gap_count_unused;

    seq_cnt_down #(.W(BW)) u_bit_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (bit_ld),
        .load_val (BW'(PAT_W - 1)),
        .dec      (bit_dec),
        .count    (bit_count),
        .zero     (bit_zero)
    );

    seq_cnt_down #(.W(REP_W)) u_rep_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (rep_ld),
        .load_val (rep_ldv),
        .dec      (rep_dec),
        .count    (rep_count_unused),
        .zero     (rep_zero)
    );

    seq_cnt_down #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (gap_ld),
        .load_val (gap_ldv),
        .dec      (gap_dec),
        .count    (gap_count_unused),
        .zero     (gap_zero)
    );

    assign bus.pat_ready      = (state == IDLE);
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dv_q;
    assign bus.frame_done     = fd_q;
    assign bus.busy           = busy_q;

    // next state, next registered outputs and counter controls
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        latch   = 1'b0;
        dout_n  = 1'b0;
        dv_n    = 1'b0;
        fd_n    = 1'b0;
        bit_ld  = 1'b0;
        bit_dec = 1'b0;
        rep_ld  = 1'b0;
        rep_ldv = '0;
        rep_dec = 1'b0;
        gap_ld  = 1'b0;
        gap_ldv = '0;
        gap_dec = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.pat_valid && !bus.abort) begin
                    latch   = 1'b1;
                    state_n = SHIFT;
                    shreg_n = bus.pat_data;
                    bit_ld  = 1'b1;
                    rep_ld  = 1'b1;
                    rep_ldv = (bus.rep_cnt == '0) ? '0
                            : bus.rep_cnt - 1'b1;
                    dout_n  = bus.pat_data[PAT_W-1];
                    dv_n    = 1'b1;
                end
            end
            SHIFT: begin
                if (!bit_zero) begin
                    shreg_n = shreg << 1;
                    bit_dec = 1'b1;
                    dout_n  = shreg[PAT_W-2];
                    dv_n    = 1'b1;
                    fd_n    = (bit_count == BW'(1)) && rep_zero;
                end else if (rep_zero) begin
                    state_n = IDLE;
                end else begin
                    rep_dec = 1'b1;
                    if (gap_l == '0) begin
                        shreg_n = pat_l;
                        bit_ld  = 1'b1;
                        dout_n  = pat_l[PAT_W-1];
                        dv_n    = 1'b1;
                    end else begin
                        state_n = GAP;
                        gap_ld  = 1'b1;
                        gap_ldv = gap_l - 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_n = SHIFT;
                    shreg_n = pat_l;
                    bit_ld  = 1'b1;
                    dout_n  = pat_l[PAT_W-1];
                    dv_n    = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && bus.abort) begin
            state_n = IDLE;
            dout_n  = 1'b0;
            dv_n    = 1'b0;
            fd_n    = 1'b0;
        end
    end

    // state, shift register, latched request and output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            shreg  <= '0;
            pat_l  <= '0;
            gap_l  <= '0;
            dout_q <= 1'b0;
            dv_q   <= 1'b0;
            fd_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            dout_q <= dout_n;
            dv_q   <= dv_n;
            fd_q   <= fd_n;
            busy_q <= (state_n != IDLE);
            if (latch) begin
                pat_l <= bus.pat_data;
                gap_l <= bus.gap_cycles;
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx.
// Reference stream is built from repetition/gap rules.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seq_pattern_tx_if #(.PAT_W(4), .REP_W(4), .GAP_W(4)) bus ();

    seq_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pat;
        int         rep;
        int         gap;
        int         exp_len;
    } vec_t;

    vec_t       tbl[8];
    logic [2:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.data_out, bus.data_out_valid, bus.frame_done,
                bus.busy, bus.pat_ready};
    endfunction

    // expected {data_out, valid, frame_done} per cycle from first bit
    task automatic build(input logic [3:0] pat, input int rep, input int gap);
        int n;
        exp_q.delete();
        n = (rep == 0) ? 1 : rep;
        for (int r = 0; r < n; r++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, (r == n - 1) && (b == 0)});
            if (r < n - 1)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(3'b000);
        end
    endtask

    task automatic request(input logic [3:0] pat, input int rep,
                           input int gap);
        chk("ready_before_req", {31'd0, bus.pat_ready}, 1);
        bus.pat_valid  = 1'b1;
        bus.pat_data   = pat;
        bus.rep_cnt    = 4'(rep);
        bus.gap_cycles = 4'(gap);
        step();
        bus.pat_valid = 1'b0;
    endtask

    task automatic follow(input logic [3:0] pat, input int rep, input int gap,
                          input bit noise, output int len);
        int n;
        build(pat, rep, gap);
        n = exp_q.size();
        len = -1;
        for (int i = 0; i < n; i++) begin
            chk("stream", {27'd0, outs()}, {27'd0, exp_q[i], 2'b10});
            if (bus.frame_done && len < 0) len = i + 1;
            if (noise) begin
                bus.pat_valid  = 1'($urandom_range(0, 1));
                bus.pat_data   = 4'($urandom);
                bus.rep_cnt    = 4'($urandom);
                bus.gap_cycles = 4'($urandom);
            end
            step();
        end
        if (noise) bus.pat_valid = 1'b0;
        chk("idle_after", {27'd0, outs()}, 32'b00001);
    endtask

    initial begin
        int len;
        tbl[0] = '{DEFAULT_PATTERN, 1, 0, 4};
        tbl[1] = '{DEFAULT_PATTERN, 3, 0, 12};
        tbl[2] = '{DEFAULT_PATTERN, 2, 2, 10};
        tbl[3] = '{DEFAULT_PATTERN, 0, 0, 4};
        tbl[4] = '{4'b0110, 2, 1, 9};
        tbl[5] = '{4'b1111, 15, 15, 270};
        tbl[6] = '{4'b0000, 1, 3, 4};
        tbl[7] = '{4'b1010, 4, 0, 16};

        bus.pat_valid  = 1'b0;
        bus.pat_data   = '0;
        bus.rep_cnt    = '0;
        bus.gap_cycles = '0;
        bus.abort      = 1'b0;

        #2;
        chk("reset_outs", {27'd0, outs()}, 32'b00001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_reset", {27'd0, outs()}, 32'b00001);

        foreach (tbl[i]) begin
            request(tbl[i].pat, tbl[i].rep, tbl[i].gap);
            follow(tbl[i].pat, tbl[i].rep, tbl[i].gap, 1'b1, len);
            chk("frame_len", len, tbl[i].exp_len);
        end

        // abort on the 2nd bit, then immediate new request
        request(DEFAULT_PATTERN, 2, 0);
        step();
        bus.abort = 1'b1;
        step();
        chk("abort_shift", {27'd0, outs()}, 32'b00001);
        bus.abort = 1'b0;
        request(4'b0110, 1, 0);
        follow(4'b0110, 1, 0, 1'b1, len);

        // abort in IDLE blocks acceptance
        bus.pat_valid  = 1'b1;
        bus.abort      = 1'b1;
        bus.pat_data   = DEFAULT_PATTERN;
        bus.rep_cnt    = 4'd1;
        bus.gap_cycles = 4'd0;
        step();
        chk("abort_idle", {27'd0, outs()}, 32'b00001);
        bus.abort = 1'b0;
        step();
        bus.pat_valid = 1'b0;
        follow(DEFAULT_PATTERN, 1, 0, 1'b1, len);

        // pat_valid held while busy: consumed only once in IDLE
        bus.pat_valid  = 1'b1;
        bus.pat_data   = DEFAULT_PATTERN;
        bus.rep_cnt    = 4'd2;
        bus.gap_cycles = 4'd1;
        step();
        bus.pat_data   = 4'b0110;
        bus.rep_cnt    = 4'd0;
        bus.gap_cycles = 4'd0;
        follow(DEFAULT_PATTERN, 2, 1, 1'b0, len);
        step();
        bus.pat_valid = 1'b0;
        follow(4'b0110, 0, 0, 1'b0, len);
        chk("held_len", len, 4);

        // asynchronous reset mid-SHIFT
        request(DEFAULT_PATTERN, 3, 0);
        step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {27'd0, outs()}, 32'b00001);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("after_reset", {27'd0, outs()}, 32'b00001);

        // randomized requests against the reference stream
        for (int k = 0; k < 20; k++) begin
            logic [3:0] p;
            int         r;
            int         g;
            p = 4'($urandom);
            r = $urandom_range(0, 4);
            g = $urandom_range(0, 3);
            request(p, r, g);
            follow(p, r, g, 1'b1, len);
            chk("rand_len", len,
                ((r == 0) ? 1 : r) * 4 + (((r == 0) ? 1 : r) - 1) * g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
